odo_core_scheduler: RTL

- Sequences a bank of NUM_CORES odocrypt hashing cores for one job: partitions the 32-bit nonce space into fixed slices and hands a slice to each idle core.
- Collects golden nonces from all cores through a round-robin arbiter into a small result FIFO.
- Presents results and job completion to the USB3 interface; aborts everything on host break.
- Sits in the clk_h domain between the job/break control logic and the per-core miner instances.

---
 rtl/odo_sched_pkg.sv | 27 ++
 rtl/odo_core_scheduler_fifo.sv | 66 ++++++
 rtl/odo_core_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/odo_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : odo_sched_pkg
// Purpose  : Shared types, constants and helpers for the odocrypt core
//            scheduler and its result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package odo_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

  // Value presented on the nonce output while no result is queued.
  localparam logic [31:0] NONCE_EMPTY = 32'hFFFF_FFFF;

  // Advance a slice base by one slice; bit 32 is the carry that marks
  // the nonce space as exhausted.
  function automatic logic [32:0] slice_inc(input logic [31:0] base,
                                            input int          slice_w);
    return {1'b0, base} + (33'd1 << slice_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/odo_core_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module   : odo_result_fifo
// Purpose  : Small synchronous FIFO for golden nonces with flush; a push
//            into a full FIFO is accepted only alongside a same-cycle pop.
// Revision : 1.0 - initial release
// ============================================================================
module odo_result_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_h,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic        full,
  output logic        empty,
  output logic [31:0] head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]   mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array; written only when an entry is actually accepted.
  always_ff @(posedge clk_h) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk_h or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/odo_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : odo_core_scheduler
// Purpose  : Hands fixed nonce slices to idle hashing cores, gathers golden
//            nonces through a round-robin arbiter into a result FIFO and
//            reports job completion; any abort stops every core at once.
// Revision : 1.0 - initial release
// ============================================================================
module odo_core_scheduler
  import odo_sched_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int SLICE_W    = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk_h,
  input  logic                   reset,
  input  logic                   start_hash,
  input  logic                   host_break,
  output logic [NUM_CORES-1:0]   core_start,
  output logic                   core_abort,
  output logic [NUM_CORES*32-1:0] core_base,
  input  logic [NUM_CORES-1:0]   core_done,
  input  logic [NUM_CORES-1:0]   core_found,
  input  logic [NUM_CORES*32-1:0] core_nonce,
  output logic                   ticket2moon,
  output logic [31:0]            nonce,
  input  logic                   nonce_ack,
  output logic                   hash_cmplt,
  output logic                   found_ovf
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_t         state, state_nx;
  logic                 start_q;
  logic [NUM_CORES-1:0] busy, done_pend, found_pend;
  logic [31:0]          next_base;
  logic                 exhausted;
  logic [IW-1:0]        rr_ptr;
  logic [31:0]          slot [NUM_CORES];

  logic                 start_rise, start_fall, abort, job_start;
  logic [NUM_CORES-1:0] avail, issue_vec, exh_free, done_accept, found_accept;
  logic [NUM_CORES-1:0] busy_nx, done_pend_nx, found_pend_nx, gnt_vec;
  logic                 issue_ok, issue, gnt_ok, ovf_set;
  logic [IW-1:0]        issue_idx, gnt_idx, cand;
  logic [32:0]          base_sum;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [31:0]          fifo_head;

  // Control decode: edges, abort, slice issue, pend bookkeeping, arbitration.
  always_comb begin
    start_rise = start_hash & ~start_q;
    start_fall = ~start_hash & start_q;
    abort      = host_break | ((state == S_RUN) & start_fall);
    job_start  = (state == S_IDLE) & start_rise & ~host_break;

    // A core whose done is pending counts as free for reissue.
    avail     = ~busy | done_pend;
    issue_ok  = 1'b0;
    issue_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (avail[i]) begin
        issue_ok  = 1'b1;
        issue_idx = IW'(i);
      end
    end
    issue     = (state == S_RUN) & ~exhausted & issue_ok & ~abort;
    issue_vec = '0;
    if (issue) issue_vec[issue_idx] = 1'b1;
    base_sum  = slice_inc(next_base, SLICE_W);

    // Once exhausted, finished cores are retired instead of reissued.
    exh_free     = ((state == S_RUN) && exhausted) ? done_pend : '0;
    done_accept  = (state == S_RUN) ? (core_done & busy & ~done_pend) : '0;
    done_pend_nx = (done_pend & ~(issue_vec | exh_free)) | done_accept;
    busy_nx      = (busy & ~exh_free) | issue_vec;

    found_accept = core_found & ((state == S_DONE) ? {NUM_CORES{1'b1}} :
                                 (state == S_RUN)  ? busy : '0);

    // Round-robin: search starts just after the last granted slot.
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int j = 1; j <= NUM_CORES; j++) begin
      cand = IW'((int'(rr_ptr) + j) % NUM_CORES);
      if (!gnt_ok && found_pend[cand]) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vec = '0;
    if (gnt_ok) gnt_vec[gnt_idx] = 1'b1;
    found_pend_nx = (found_pend & ~gnt_vec) | found_accept;

    fifo_pop  = nonce_ack & ~fifo_empty;
    fifo_push = gnt_ok & (~fifo_full | fifo_pop);
    ovf_set   = (|(found_accept & found_pend & ~gnt_vec)) |
                (gnt_ok & fifo_full & ~fifo_pop);
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (job_start) state_nx = S_RUN;
      S_RUN:   if (exhausted && (busy_nx == '0)) state_nx = S_DONE;
      S_DONE:  if (start_fall) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk_h or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Job datapath: core masks, slice bases, found slots and sticky overflow.
  always_ff @(posedge clk_h or posedge reset) begin
    if (reset) begin
      start_q    <= 1'b0;
      busy       <= '0;
      done_pend  <= '0;
      found_pend <= '0;
      next_base  <= '0;
      exhausted  <= 1'b0;
      rr_ptr     <= IW'(NUM_CORES - 1);
      core_start <= '0;
      core_abort <= 1'b0;
      core_base  <= '0;
      found_ovf  <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) slot[i] <= '0;
    end else begin
      start_q    <= start_hash;
      core_start <= '0;
      core_abort <= abort;
      if (abort) begin
        busy       <= '0;
        done_pend  <= '0;
        found_pend <= '0;
      end else if (job_start) begin
        busy       <= '0;
        done_pend  <= '0;
        found_pend <= '0;
        next_base  <= '0;
        exhausted  <= 1'b0;
        rr_ptr     <= IW'(NUM_CORES - 1);
        found_ovf  <= 1'b0;
      end else begin
        busy       <= busy_nx;
        done_pend  <= done_pend_nx;
        found_pend <= found_pend_nx;
        if (gnt_ok)  rr_ptr    <= gnt_idx;
        if (ovf_set) found_ovf <= 1'b1;
        if (issue) begin
          core_start                          <= issue_vec;
          core_base[32*int'(issue_idx) +: 32] <= next_base;
          next_base                           <= base_sum[31:0];
          if (base_sum[32]) exhausted <= 1'b1;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
          if (found_accept[i]) slot[i] <= core_nonce[32*i +: 32];
        end
      end
    end
  end

  odo_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_h (clk_h),
    .reset (reset),
    .flush (abort | job_start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (slot[gnt_idx]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign ticket2moon = ~fifo_empty;
  assign nonce       = fifo_empty ? NONCE_EMPTY : fifo_head;
  assign hash_cmplt  = (state == S_DONE);

endmodule
`default_nettype wire
